// File: rtl/placement_pkg.sv
// Shared defaults for the placement index unit: widths, strip count, invalid
// coordinate and the reset-time strip-to-y offset table.
package placement_pkg;

  localparam int unsigned COORD_W_DEF       = 8;
  localparam int unsigned STRIP_W_DEF       = 4;
  localparam int unsigned NUM_STRIPS_DEF    = 13;
  localparam int unsigned STRIKE_W_DEF      = 4;
  localparam int unsigned INVALID_COORD_DEF = 128;
  localparam int unsigned CNT_W_DEF         = 16;

  // Indexed directly by strip ID; ID 0 and IDs past the default set hold 0.
  localparam int unsigned Y_DEFAULT_DEPTH = 16;
  localparam int unsigned Y_DEFAULTS [Y_DEFAULT_DEPTH] =
    '{0, 0, 8, 16, 25, 32, 42, 48, 59, 64, 76, 80, 96, 112, 0, 0};

  typedef enum logic [1:0] {
    RES_PLACED    = 2'd0,
    RES_STRUCK    = 2'd1,
    RES_RANGE_ERR = 2'd2
  } res_kind_e;

endpackage

// File: rtl/strip_y_table.sv
// Runtime-programmable strip-ID to y-offset table: synchronous write,
// combinational read, reset to the package defaults.
module strip_y_table
  import placement_pkg::*;
#(
  parameter int unsigned COORD_W    = COORD_W_DEF,
  parameter int unsigned STRIP_W    = STRIP_W_DEF,
  parameter int unsigned NUM_STRIPS = NUM_STRIPS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [STRIP_W-1:0] wr_addr,
  input  logic [COORD_W-1:0] wr_data,
  input  logic [STRIP_W-1:0] rd_addr,
  output logic [COORD_W-1:0] rd_data
);

  logic [COORD_W-1:0] rd_vec [2**STRIP_W];

  // Every address decodes to a slot; slots outside 1..NUM_STRIPS read as
  // zero and silently absorb writes.
  for (genvar g = 0; g < 2**STRIP_W; g++) begin : g_entry
    if (g >= 1 && g <= NUM_STRIPS) begin : g_live
      localparam int unsigned DEF =
        (g < Y_DEFAULT_DEPTH) ? Y_DEFAULTS[g % Y_DEFAULT_DEPTH] : 0;
      logic [COORD_W-1:0] entry_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          entry_q <= COORD_W'(DEF);
        end else if (wr_en && wr_addr == STRIP_W'(g)) begin
          entry_q <= wr_data;
        end
      end

      assign rd_vec[g] = entry_q;
    end else begin : g_dead
      assign rd_vec[g] = '0;
    end
  end

  assign rd_data = rd_vec[rd_addr];

endmodule

// File: rtl/placement_index_unit.sv
// Converts granted placements into registered (x, y) indices with valid/ready
// flow control, strip range checking and saturating placement/strike counters.
module placement_index_unit
  import placement_pkg::*;
#(
  parameter int unsigned COORD_W       = COORD_W_DEF,
  parameter int unsigned STRIP_W       = STRIP_W_DEF,
  parameter int unsigned NUM_STRIPS    = NUM_STRIPS_DEF,
  parameter int unsigned STRIKE_W      = STRIKE_W_DEF,
  parameter int unsigned INVALID_COORD = INVALID_COORD_DEF,
  parameter int unsigned X_FROM_ONE    = 0,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [STRIP_W-1:0]  cfg_addr,
  input  logic [COORD_W-1:0]  cfg_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [STRIP_W-1:0]  strip_id_in,
  input  logic [COORD_W-1:0]  occupied_width_in,
  input  logic [STRIKE_W-1:0] strike_in,
  input  logic                strike_flag_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [COORD_W-1:0]  x_out,
  output logic [COORD_W-1:0]  y_out,
  output logic [STRIKE_W-1:0] strike_out,
  output logic                range_err_out,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    placed_cnt,
  output logic [CNT_W-1:0]    struck_cnt
);

  localparam logic [STRIP_W-1:0] MAX_ID  = STRIP_W'(NUM_STRIPS);
  localparam logic [COORD_W-1:0] INV_XY  = COORD_W'(INVALID_COORD);

  logic [COORD_W-1:0] table_y;
  logic [COORD_W-1:0] x_next;
  logic [COORD_W-1:0] y_next;
  res_kind_e          kind_next;
  res_kind_e          kind_q;
  logic               accept;
  logic               deliver;

  strip_y_table #(
    .COORD_W    (COORD_W),
    .STRIP_W    (STRIP_W),
    .NUM_STRIPS (NUM_STRIPS)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cfg_we),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_addr (strip_id_in),
    .rd_data (table_y)
  );

  assign in_ready      = rst || !out_valid || out_ready;
  assign accept        = in_valid && in_ready;
  assign deliver       = out_valid && out_ready;
  assign range_err_out = (kind_q == RES_RANGE_ERR);

  always_comb begin
    x_next    = INV_XY;
    y_next    = INV_XY;
    kind_next = RES_PLACED;
    if (strike_flag_in) begin
      kind_next = RES_STRUCK;
    end else if (strip_id_in == '0 || strip_id_in > MAX_ID) begin
      kind_next = RES_RANGE_ERR;
    end else begin
      y_next = table_y;
      if (X_FROM_ONE != 0) begin
        x_next = (occupied_width_in == '0) ? '0 : occupied_width_in - 1'b1;
      end else begin
        x_next = occupied_width_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      strike_out <= '0;
      kind_q     <= RES_PLACED;
    end else if (accept) begin
      out_valid  <= 1'b1;
      x_out      <= x_next;
      y_out      <= y_next;
      strike_out <= strike_in;
      kind_q     <= kind_next;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      placed_cnt <= '0;
      struck_cnt <= '0;
    end else if (deliver) begin
      if (kind_q == RES_PLACED) begin
        if (placed_cnt != '1) placed_cnt <= placed_cnt + 1'b1;
      end else begin
        if (struck_cnt != '1) struck_cnt <= struck_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_placement_index_unit.sv
// Randomised check of placement_index_unit (default and X_FROM_ONE/CNT_W=2
// instances) against a transaction-level reference model.
module tb_placement_index_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       in_valid;
  logic [3:0] strip_id_in;
  logic [7:0] occupied_width_in;
  logic [3:0] strike_in;
  logic       strike_flag_in;
  logic       out_ready;
  logic       cnt_clr;

  logic        in_ready_a, out_valid_a, range_err_a;
  logic [7:0]  x_a, y_a;
  logic [3:0]  strike_a;
  logic [15:0] placed_a, struck_a;

  logic        in_ready_b, out_valid_b, range_err_b;
  logic [7:0]  x_b, y_b;
  logic [3:0]  strike_b;
  logic [1:0]  placed_b, struck_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  placement_index_unit dut_a (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready_a), .strip_id_in(strip_id_in),
    .occupied_width_in(occupied_width_in), .strike_in(strike_in),
    .strike_flag_in(strike_flag_in), .out_valid(out_valid_a), .out_ready(out_ready),
    .x_out(x_a), .y_out(y_a), .strike_out(strike_a), .range_err_out(range_err_a),
    .cnt_clr(cnt_clr), .placed_cnt(placed_a), .struck_cnt(struck_a)
  );

  placement_index_unit #(.X_FROM_ONE(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready_b), .strip_id_in(strip_id_in),
    .occupied_width_in(occupied_width_in), .strike_in(strike_in),
    .strike_flag_in(strike_flag_in), .out_valid(out_valid_b), .out_ready(out_ready),
    .x_out(x_b), .y_out(y_b), .strike_out(strike_b), .range_err_out(range_err_b),
    .cnt_clr(cnt_clr), .placed_cnt(placed_b), .struck_cnt(struck_b)
  );

  // Reference model state
  int  m_tab [16];
  bit  m_v;
  int  m_x, m_x1, m_y, m_s;
  bit  m_re, m_st;
  int  m_placed, m_struck, m_placed2, m_struck2;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    int defs [14] = '{0, 0, 8, 16, 25, 32, 42, 48, 59, 64, 76, 80, 96, 112};
    for (int i = 0; i < 16; i++) m_tab[i] = (i < 14) ? defs[i] : 0;
    m_v = 0; m_x = 0; m_x1 = 0; m_y = 0; m_s = 0; m_re = 0; m_st = 0;
    m_placed = 0; m_struck = 0; m_placed2 = 0; m_struck2 = 0;
  endtask

  task automatic check_outputs();
    check_eq("out_valid_a", out_valid_a, m_v);
    check_eq("out_valid_b", out_valid_b, m_v);
    check_eq("x_a", x_a, m_x);
    check_eq("x_b", x_b, m_x1);
    check_eq("y_a", y_a, m_y);
    check_eq("y_b", y_b, m_y);
    check_eq("strike_a", strike_a, m_s);
    check_eq("strike_b", strike_b, m_s);
    check_eq("range_err_a", range_err_a, m_re);
    check_eq("range_err_b", range_err_b, m_re);
    check_eq("placed_a", placed_a, m_placed);
    check_eq("struck_a", struck_a, m_struck);
    check_eq("placed_b", placed_b, m_placed2);
    check_eq("struck_b", struck_b, m_struck2);
  endtask

  // One clock: drive at negedge, check in_ready, advance model, check results.
  task automatic cycle(input bit r, input bit iv, input int id, input int w, input int s,
                       input bit sf, input bit ordy, input bit we, input int wa,
                       input int wd, input bit clr);
    bit acc, dlv, good;
    rst = r; in_valid = iv; strip_id_in = 4'(id); occupied_width_in = 8'(w);
    strike_in = 4'(s); strike_flag_in = sf; out_ready = ordy;
    cfg_we = we; cfg_addr = 4'(wa); cfg_data = 8'(wd); cnt_clr = clr;
    #1;
    check_eq("in_ready_a", in_ready_a, r ? 1 : int'(!m_v || ordy));
    check_eq("in_ready_b", in_ready_b, r ? 1 : int'(!m_v || ordy));
    if (r) begin
      model_reset();
    end else begin
      acc  = iv && (!m_v || ordy);
      dlv  = m_v && ordy;
      good = !m_st && !m_re;
      if (clr) begin
        m_placed = 0; m_struck = 0; m_placed2 = 0; m_struck2 = 0;
      end else if (dlv) begin
        if (good) begin
          m_placed  = (m_placed  < 65535) ? m_placed  + 1 : 65535;
          m_placed2 = (m_placed2 < 3)     ? m_placed2 + 1 : 3;
        end else begin
          m_struck  = (m_struck  < 65535) ? m_struck  + 1 : 65535;
          m_struck2 = (m_struck2 < 3)     ? m_struck2 + 1 : 3;
        end
      end
      if (acc) begin
        m_v = 1; m_s = s; m_st = sf;
        m_re = !sf && (id == 0 || id > 13);
        if (sf || m_re) begin
          m_x = 128; m_x1 = 128; m_y = 128;
        end else begin
          m_x = w; m_x1 = (w == 0) ? 0 : w - 1; m_y = m_tab[id];
        end
      end else if (ordy) begin
        m_v = 0;
      end
      if (we && wa >= 1 && wa <= 13) m_tab[wa] = wd;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input bit ordy);
    cycle(0, 0, 0, 0, 0, 0, ordy, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 4, 10, 0, 0, 1, 0, 0, 0, 0);

    // Default table: strip 4, width 10
    cycle(0, 1, 4, 10, 5, 0, 1, 0, 0, 0, 0);
    check_eq("plan_x10", x_a, 10);
    check_eq("plan_y25", y_a, 25);
    check_eq("plan_x1_9", x_b, 9);
    idle(1);
    check_eq("plan_placed1", placed_a, 1);

    // Strike beats range error on strip 0
    cycle(0, 1, 0, 33, 3, 1, 1, 0, 0, 0, 0);
    check_eq("plan_strike_x", x_a, 128);
    check_eq("plan_strike_re", range_err_a, 0);
    // Range error on strip 14; table write to 14 is dropped
    cycle(0, 1, 14, 20, 1, 0, 1, 1, 14, 77, 0);
    check_eq("plan_range_re", range_err_a, 1);
    // Write strip 2 -> 40 while accepting strip 2: old value wins
    cycle(0, 1, 2, 6, 0, 0, 1, 1, 2, 40, 0);
    check_eq("plan_y_old", y_a, 8);
    cycle(0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0);
    check_eq("plan_y_new", y_a, 40);
    check_eq("plan_x1_w0", x_b, 0);
    cycle(0, 1, 1, 7, 0, 0, 1, 0, 0, 0, 0);
    check_eq("plan_x1_w7", x_b, 6);

    // Backpressure for 5 cycles, then 8 back-to-back requests
    for (int i = 0; i < 5; i++) cycle(0, 1, 3, 50 + i, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, i + 1, 100 + i, i, 0, 1, 0, 0, 0, 0);
    idle(1);
    // Clear wins over a concurrent delivery
    cycle(0, 1, 5, 9, 0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    check_eq("plan_clr_placed", placed_a, 0);
    // Reset with a result pending
    cycle(0, 1, 6, 9, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) < 7),
            int'($urandom_range(0, 15)),
            int'($urandom_range(0, 255)),
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 4) == 0),
            int'($urandom_range(0, 15)),
            int'($urandom_range(0, 255)),
            ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
